// File: rtl/ram_dma_master_if.sv
// Data-RAM bus seen by a DMA initiator: arbiter request/grant plus the
// addr/data/sel/we/ce access port with combinational read data.
interface ram_dma_master_if;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_sel;
    logic        ram_we;
    logic        ram_ce;

    modport master (
        output bus_req, ram_addr, ram_wdata, ram_sel, ram_we, ram_ce,
        input  bus_gnt, ram_rdata
    );

    modport slave (
        input  bus_req, ram_addr, ram_wdata, ram_sel, ram_we, ram_ce,
        output bus_gnt, ram_rdata
    );
endinterface

// File: rtl/ram_dma_master.sv
// Block fill / copy engine for the data RAM, sharing the bus with the CPU
// through an external req/gnt arbiter.
// Optional feature macro: DMA_ABORT_EN adds abort_i / aborted_o.
// Bus access outputs are decoded combinationally from state and grant so that
// a dropped grant silences the bus in the same cycle.
module ram_dma_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      fill_data_i,
`ifdef DMA_ABORT_EN
    input  logic             abort_i,
    output logic             aborted_o,
`endif
    output logic             busy_o,
    output logic             done_o,
    ram_dma_master_if.master bus
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [DW-1:0]    buf_q, buf_d;
    logic [DW-1:0]    fill_q, fill_d;
    logic             mode_q, mode_d;
    logic             busy_q, done_q, req_q;
    logic             abort_hit;
    logic             active_d;
`ifdef DMA_ABORT_EN
    logic             aborted_q;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            buf_q     <= '0;
            fill_q    <= '0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
`ifdef DMA_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            mode_q    <= mode_d;
            busy_q    <= active_d;
            done_q    <= (state_d == S_FIN);
            req_q     <= active_d;
`ifdef DMA_ABORT_EN
            aborted_q <= abort_hit;
`endif
        end
    end

    // Next-state and datapath update; every stall holds all registers
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        buf_d     = buf_q;
        fill_d    = fill_q;
        mode_d    = mode_q;
        abort_hit = 1'b0;
        active_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d = mode_i;
                    src_d  = {src_addr_i[AW-1:2], 2'b00};
                    dst_d  = {dst_addr_i[AW-1:2], 2'b00};
                    rem_d  = len_i;
                    fill_d = fill_data_i;
                    state_d = (len_i == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.bus_gnt) begin
                    state_d = mode_q ? S_RD : S_WR;
                end
            end
            S_RD: begin
                if (bus.bus_gnt) begin
                    buf_d   = bus.ram_rdata;
                    src_d   = src_q + AW'(4);
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (bus.bus_gnt) begin
                    dst_d = dst_q + AW'(4);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = mode_q ? S_RD : S_WR;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DMA_ABORT_EN
        // Abort overrides the sequencing but lets a granted write land
        if (abort_i && (state_q == S_REQ || state_q == S_RD || state_q == S_WR)) begin
            state_d   = S_FIN;
            abort_hit = 1'b1;
        end
`endif

        active_d = (state_d == S_REQ) || (state_d == S_RD) || (state_d == S_WR);
    end

    // Bus drive: all access signals are zero unless a granted RD/WR is in flight
    always_comb begin
        bus.ram_ce    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_sel   = 4'b0000;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (bus.bus_gnt && state_q == S_RD) begin
            bus.ram_ce   = 1'b1;
            bus.ram_sel  = 4'b1111;
            bus.ram_addr = src_q;
        end else if (bus.bus_gnt && state_q == S_WR) begin
            bus.ram_ce    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_sel   = 4'b1111;
            bus.ram_addr  = dst_q;
            bus.ram_wdata = mode_q ? buf_q : fill_q;
        end
    end

    assign bus.bus_req = req_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
`ifdef DMA_ABORT_EN
    assign aborted_o   = aborted_q;
`endif

endmodule

// File: tb/tb_ram_dma_master.sv
// Directed bench for ram_dma_master: a 256-word RAM model (byte address bits
// [9:2]) with combinational read, plus a write/access logger.
module tb_ram_dma_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic [31:0] fill_data_i = '0;
    logic        busy_o, done_o;
    logic        gnt = 1'b1;
`ifdef DMA_ABORT_EN
    logic        abort_i = 1'b0;
    logic        aborted_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // monitor-owned state
    logic [31:0] mem [0:255];
    int          wr_cnt = 0, ce_cnt = 0, done_cnt = 0, cyc = 0;
    logic [31:0] wr_addr_log [0:15];
    int          wr_cyc_log [0:15];
    logic        clr_req = 1'b0, load_req = 1'b0;
    logic [7:0]  load_idx = '0;
    logic [31:0] load_val = '0;

    ram_dma_master_if bus ();

    ram_dma_master #(.LEN_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .len_i       (len_i),
        .fill_data_i (fill_data_i),
`ifdef DMA_ABORT_EN
        .abort_i     (abort_i),
        .aborted_o   (aborted_o),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.bus_gnt   = gnt;
    assign bus.ram_rdata = (bus.ram_ce && !bus.ram_we) ? mem[bus.ram_addr[9:2]] : 32'd0;

    // RAM write port and access logging
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_req) begin
            wr_cnt   <= 0;
            ce_cnt   <= 0;
            done_cnt <= 0;
        end else begin
            if (bus.ram_ce) ce_cnt <= ce_cnt + 1;
            if (done_o) done_cnt <= done_cnt + 1;
            if (bus.ram_ce && bus.ram_we) begin
                wr_addr_log[wr_cnt[3:0]] <= bus.ram_addr;
                wr_cyc_log[wr_cnt[3:0]]  <= cyc;
                wr_cnt <= wr_cnt + 1;
            end
        end
        if (load_req) mem[load_idx] <= load_val;
        else if (bus.ram_ce && bus.ram_we) mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
    end

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        load_req = 1'b1; load_idx = idx; load_val = val;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] l, input logic [31:0] f);
        @(negedge clk);
        start_i = 1'b1; mode_i = m; src_addr_i = s; dst_addr_i = d; len_i = l; fill_data_i = f;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output bit ab);
        seen = 1'b0;
        ab   = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1'b1;
`ifdef DMA_ABORT_EN
                ab = aborted_o;
`endif
            end
        end
    endtask

    task automatic test_reset();
        bit seen;
        logic [72:0] outs;
        repeat (2) @(negedge clk);
        outs = {busy_o, done_o, bus.bus_req, bus.ram_ce, bus.ram_we, bus.ram_sel, bus.ram_addr, bus.ram_wdata};
        n_checks++;
        if (outs !== 73'd0) begin n_errors++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) poke(8'(128 + i), 32'd0);
        clr();
        issue(1'b0, 32'd0, 32'h200, 16'd8, 32'h1234_5678);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wr_cnt == 3) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL reset_mid_reach got=%0d writes exp=3", wr_cnt); end
        rst_n = 1'b0;
        @(negedge clk);
        outs = {busy_o, done_o, bus.bus_req, bus.ram_ce, bus.ram_we, bus.ram_sel, bus.ram_addr, bus.ram_wdata};
        n_checks++;
        if (outs !== 73'd0) begin n_errors++; $display("FAIL reset_mid_outputs got=%h exp=0", outs); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_cnt !== 3 || done_cnt !== 0) begin
            n_errors++; $display("FAIL reset_mid_counts got wr=%0d done=%0d exp wr=3 done=0", wr_cnt, done_cnt);
        end
        n_checks++;
        if (mem[128] !== 32'h1234_5678 || mem[130] !== 32'h1234_5678 || mem[131] !== 32'd0) begin
            n_errors++; $display("FAIL reset_mid_mem got=%h,%h exp=12345678,0", mem[130], mem[131]);
        end
    endtask

    task automatic test_fill();
        bit seen, ab;
        clr();
        issue(1'b0, 32'd0, 32'h100, 16'd4, 32'hA5A5_A5A5);
        wait_done(20, seen, ab);
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL fill_done got=timeout exp=done"); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_cnt !== 4 || done_cnt !== 1) begin
            n_errors++; $display("FAIL fill_counts got wr=%0d done=%0d exp wr=4 done=1", wr_cnt, done_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_addr_log[i] !== 32'h100 + 32'(4 * i) || mem[64 + i] !== 32'hA5A5_A5A5) begin
                n_errors++;
                $display("FAIL fill_word%0d got addr=%h data=%h exp addr=%h data=a5a5a5a5",
                         i, wr_addr_log[i], mem[64 + i], 32'h100 + 32'(4 * i));
            end
        end
        n_checks++;
        if (wr_cyc_log[3] - wr_cyc_log[0] !== 3) begin
            n_errors++; $display("FAIL fill_consecutive got span=%0d exp=3", wr_cyc_log[3] - wr_cyc_log[0]);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin n_errors++; $display("FAIL fill_busy_after got=%b exp=0", busy_o); end
    endtask

    task automatic test_copy();
        bit seen, ab;
        poke(8'd0, 32'd1); poke(8'd1, 32'd2); poke(8'd2, 32'd3);
        clr();
        issue(1'b1, 32'h0, 32'h40, 16'd3, 32'hDEAD_BEEF);
        wait_done(30, seen, ab);
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL copy_done got=timeout exp=done"); end
        @(negedge clk);
        n_checks++;
        if (ce_cnt !== 6 || wr_cnt !== 3) begin
            n_errors++; $display("FAIL copy_counts got ce=%0d wr=%0d exp ce=6 wr=3", ce_cnt, wr_cnt);
        end
        n_checks++;
        if (mem[16] !== 32'd1 || mem[17] !== 32'd2 || mem[18] !== 32'd3) begin
            n_errors++; $display("FAIL copy_data got=%h,%h,%h exp=1,2,3", mem[16], mem[17], mem[18]);
        end
    endtask

    task automatic test_grant_loss();
        bit seen, ab;
        poke(8'd4, 32'h11); poke(8'd5, 32'h22); poke(8'd32, 32'd0); poke(8'd33, 32'd0);
        clr();
        issue(1'b1, 32'h10, 32'h80, 16'd2, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.ram_ce === 1'b1 && bus.ram_we === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL gnt_first_wr got=timeout exp=wr"); end
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) #1; else @(negedge clk);
            n_checks++;
            if (bus.ram_ce !== 1'b0 || bus.ram_addr !== 32'd0 || busy_o !== 1'b1) begin
                n_errors++; $display("FAIL gnt_stall%0d got ce=%b addr=%h busy=%b exp ce=0 addr=0 busy=1",
                                     i, bus.ram_ce, bus.ram_addr, busy_o);
            end
        end
        @(negedge clk);
        gnt = 1'b1;
        #1;
        n_checks++;
        if (bus.ram_ce !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h80 || bus.ram_wdata !== 32'h11) begin
            n_errors++; $display("FAIL gnt_reissue got ce=%b we=%b addr=%h data=%h exp 1,1,00000080,00000011",
                                 bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        wait_done(20, seen, ab);
        n_checks++;
        if (!seen || wr_cnt !== 2 || mem[32] !== 32'h11 || mem[33] !== 32'h22) begin
            n_errors++; $display("FAIL gnt_result got done=%b wr=%0d data=%h,%h exp 1,2,11,22",
                                 seen, wr_cnt, mem[32], mem[33]);
        end
    endtask

    task automatic test_edges();
        bit seen, ab;
        // zero length: done quickly, no access
        clr();
        issue(1'b0, 32'd0, 32'h100, 16'd0, 32'hFFFF_FFFF);
        seen = (done_o === 1'b1);
        if (!seen) begin
            @(negedge clk);
            seen = (done_o === 1'b1);
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL len0_done got=%b exp=1", done_o); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ce_cnt !== 0 || done_cnt !== 1 || mem[64] !== 32'hA5A5_A5A5) begin
            n_errors++; $display("FAIL len0_noaccess got ce=%0d done=%0d exp ce=0 done=1", ce_cnt, done_cnt);
        end
        // address wrap
        poke(8'd255, 32'd0);
        clr();
        issue(1'b0, 32'd0, 32'hFFFF_FFFC, 16'd2, 32'h5A5A_0001);
        wait_done(20, seen, ab);
        n_checks++;
        if (!seen || wr_addr_log[0] !== 32'hFFFF_FFFC || wr_addr_log[1] !== 32'h0) begin
            n_errors++; $display("FAIL wrap_addr got=%h,%h exp=fffffffc,00000000", wr_addr_log[0], wr_addr_log[1]);
        end
        n_checks++;
        if (mem[255] !== 32'h5A5A_0001 || mem[0] !== 32'h5A5A_0001) begin
            n_errors++; $display("FAIL wrap_data got=%h,%h exp=5a5a0001", mem[255], mem[0]);
        end
        // unaligned source
        poke(8'd64, 32'hCAFE_0001); poke(8'd48, 32'd0);
        clr();
        issue(1'b1, 32'h103, 32'hC2, 16'd1, 32'd0);
        wait_done(20, seen, ab);
        n_checks++;
        if (!seen || wr_addr_log[0] !== 32'hC0 || mem[48] !== 32'hCAFE_0001) begin
            n_errors++; $display("FAIL unaligned got addr=%h data=%h exp addr=000000c0 data=cafe0001",
                                 wr_addr_log[0], mem[48]);
        end
    endtask

    task automatic test_busy_start();
        bit seen, ab;
        poke(8'd224, 32'd0);
        clr();
        issue(1'b0, 32'd0, 32'h300, 16'd4, 32'h0BAD_F00D);
        @(negedge clk);
        start_i = 1'b1; mode_i = 1'b0; dst_addr_i = 32'h380; len_i = 16'd1; fill_data_i = 32'h7777_7777;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(20, seen, ab);
        repeat (6) @(negedge clk);
        n_checks++;
        if (!seen || done_cnt !== 1 || wr_cnt !== 4 || mem[224] !== 32'd0 || busy_o !== 1'b0) begin
            n_errors++; $display("FAIL busy_start got done=%0d wr=%0d mem=%h exp done=1 wr=4 mem=0",
                                 done_cnt, wr_cnt, mem[224]);
        end
    endtask

`ifdef DMA_ABORT_EN
    task automatic test_abort();
        bit seen, ab;
        clr();
        issue(1'b0, 32'd0, 32'h280, 16'd10, 32'h0A0B_0C0D);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wr_cnt >= 2) seen = 1'b1;
        end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        seen = (done_o === 1'b1);
        ab   = (aborted_o === 1'b1);
        if (!seen) wait_done(20, seen, ab);
        n_checks++;
        if (!seen || !ab) begin n_errors++; $display("FAIL abort_flag got done=%b aborted=%b exp 1,1", seen, ab); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_cnt >= 10 || aborted_o !== 1'b0) begin
            n_errors++; $display("FAIL abort_writes got wr=%0d aborted=%b exp wr<10 aborted=0", wr_cnt, aborted_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_grant_loss();
        test_edges();
        test_busy_start();
`ifdef DMA_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
